// File: rtl/sounder.sv
// sounder: PN-sequence channel sounder core.
//
// The transmitter sends a maximal-length PN code (degree 2..16) as +/-AMPL on
// the TX I path, one chip every two clocks. The receiver correlates the I
// (and optionally Q) input against a local reference copy of the code. It
// emits one impulse-response sample per code period. The reference slips one
// chip per period, so successive samples step through every lag.
//
// Ports
//   clk_i        system clock (single domain)
//   rst_n_i      synchronous active-low reset
//   saddr_i      config register address (MODE=64, DEGREE=65, AMPL=66)
//   sdata_i      config write data
//   s_strobe_i   config write strobe
//   tx_strobe_o  one pulse per transmitted chip
//   tx_dac_i_o   TX I sample, two's complement
//   tx_dac_q_o   TX Q sample, tied to 0
//   rx_strobe_o  pulse when rx_imp_*_o carries a new sample
//   rx_adc_i_i   RX I sample
//   rx_adc_q_i   RX Q sample
//   rx_imp_i_o   impulse-response sample, I
//   rx_imp_q_o   impulse-response sample, Q
//
// Optional build macro SOUNDER_Q_CHANNEL_EN: when defined, a Q correlator
// runs alongside I. Otherwise no Q hardware is built and rx_imp_q_o is 0.

module sounder (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [6:0]  saddr_i,
  input  logic [31:0] sdata_i,
  input  logic        s_strobe_i,
  output logic        tx_strobe_o,
  output logic [13:0] tx_dac_i_o,
  output logic [13:0] tx_dac_q_o,
  output logic        rx_strobe_o,
  input  logic [15:0] rx_adc_i_i,
  input  logic [15:0] rx_adc_q_i,
  output logic [15:0] rx_imp_i_o,
  output logic [15:0] rx_imp_q_o
);

  localparam logic [6:0] FR_MODE   = 7'd64;
  localparam logic [6:0] FR_DEGREE = 7'd65;
  localparam logic [6:0] FR_AMPL   = 7'd66;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s,
                                            input logic [15:0] taps,
                                            input logic [15:0] mask);
    return {s[14:0], ^(s & taps)} & mask;
  endfunction

  // pn=1 passes the sample, pn=0 negates it; 17 bits so -(-32768) fits
  function automatic logic [16:0] corr_prod(input logic [15:0] x, input logic pn);
    logic [16:0] sx;
    sx = {x[15], x};
    return pn ? sx : (~sx + 17'd1);
  endfunction

  function automatic logic [15:0] sat16(input logic [31:0] v, input logic [5:0] sh);
    logic signed [31:0] s;
    s = $signed(v) >>> sh;
    if (s > 32'sd32767)       return 16'h7FFF;
    else if (s < -32'sd32768) return 16'h8000;
    else                      return s[15:0];
  endfunction

  // ---------------- configuration registers ----------------
  logic [3:0]  mode_q, mode_d;
  logic [5:0]  degree_q, degree_d;
  logic [13:0] ampl_q, ampl_d;

  always_comb begin
    mode_d   = mode_q;
    degree_d = degree_q;
    ampl_d   = ampl_q;
    if (s_strobe_i) begin
      case (saddr_i)
        FR_MODE:   mode_d   = sdata_i[3:0];
        FR_DEGREE: degree_d = sdata_i[5:0];
        FR_AMPL:   ampl_d   = sdata_i[13:0];
        default:   ;
      endcase
    end
  end

  // ---------------- degree decode ----------------
  logic [15:0] taps;
  logic        deg_valid;
  logic [16:0] span;       // N = 2^degree - 1
  logic [15:0] mask;
  logic [15:0] msb_mask;
  logic [16:0] last_cnt;

  always_comb begin
    case (degree_q)
      6'd2:    taps = 16'h0003;
      6'd3:    taps = 16'h0006;
      6'd4:    taps = 16'h000C;
      6'd5:    taps = 16'h0014;
      6'd6:    taps = 16'h0030;
      6'd7:    taps = 16'h0060;
      6'd8:    taps = 16'h00B8;
      6'd9:    taps = 16'h0110;
      6'd10:   taps = 16'h0240;
      6'd11:   taps = 16'h0500;
      6'd12:   taps = 16'h0829;
      6'd13:   taps = 16'h100D;
      6'd14:   taps = 16'h2015;
      6'd15:   taps = 16'h6000;
      6'd16:   taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    deg_valid = (taps != 16'h0000);
    span      = (17'd1 << degree_q[4:0]) - 17'd1;
    mask      = span[15:0];
    msb_mask  = mask ^ {1'b0, mask[15:1]};
    last_cnt  = span - 17'd1;
  end

  // ---------------- datapath ----------------
  logic        soft_rst;
  logic        phase_q, phase_d;
  logic [15:0] tx_lfsr_q, tx_lfsr_d;
  logic [15:0] ref_lfsr_q, ref_lfsr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [13:0] tx_dac_q, tx_dac_d;
  logic        rx_strobe_q, rx_strobe_d;
  logic [31:0] acc_i_q, acc_i_d, acc_i_nxt;
  logic [15:0] imp_i_q, imp_i_d;
  logic        tx_pn, ref_pn, tx_go, rx_go, period_end;
  logic [15:0] x_i;
  logic [16:0] prod_i;

  assign soft_rst = mode_q[0];

  always_comb begin
    tx_pn      = |(tx_lfsr_q & msb_mask);
    ref_pn     = |(ref_lfsr_q & msb_mask);
    tx_go      = phase_q & mode_q[1] & deg_valid;
    rx_go      = phase_q & mode_q[2] & deg_valid;
    period_end = rx_go & ({1'b0, cnt_q} == last_cnt);
    x_i        = mode_q[3] ? {tx_dac_q, 2'b00} : rx_adc_i_i;
    prod_i     = corr_prod(x_i, ref_pn);
    acc_i_nxt  = acc_i_q + {{15{prod_i[16]}}, prod_i};

    phase_d     = ~phase_q;
    tx_lfsr_d   = tx_go ? lfsr_step(tx_lfsr_q, taps, mask) : tx_lfsr_q;
    ref_lfsr_d  = ref_lfsr_q;
    cnt_d       = cnt_q;
    acc_i_d     = acc_i_q;
    imp_i_d     = imp_i_q;
    rx_strobe_d = 1'b0;

    // DAC is refreshed every clock from the current LFSR head, so the new
    // chip value appears together with tx_strobe_o and the loopback
    // receiver sees the chip that its reference is pointing at.
    tx_dac_d = 14'd0;
    if (mode_q[1] && deg_valid) tx_dac_d = tx_pn ? ampl_q : (~ampl_q + 14'd1);

    if (rx_go) begin
      if (period_end) begin
        // reference holds here: this is the one-chip slip per period
        acc_i_d     = 32'd0;
        cnt_d       = 16'd0;
        imp_i_d     = sat16(acc_i_nxt, degree_q);
        rx_strobe_d = 1'b1;
      end else begin
        acc_i_d    = acc_i_nxt;
        cnt_d      = cnt_q + 16'd1;
        ref_lfsr_d = lfsr_step(ref_lfsr_q, taps, mask);
      end
    end

    if (soft_rst) begin
      phase_d     = 1'b0;
      tx_lfsr_d   = mask;
      ref_lfsr_d  = mask;
      cnt_d       = 16'd0;
      acc_i_d     = 32'd0;
      imp_i_d     = 16'd0;
      tx_dac_d    = 14'd0;
      rx_strobe_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mode_q      <= '0;
      degree_q    <= '0;
      ampl_q      <= '0;
      phase_q     <= 1'b0;
      tx_lfsr_q   <= '0;
      ref_lfsr_q  <= '0;
      cnt_q       <= '0;
      acc_i_q     <= '0;
      imp_i_q     <= '0;
      tx_dac_q    <= '0;
      rx_strobe_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      degree_q    <= degree_d;
      ampl_q      <= ampl_d;
      phase_q     <= phase_d;
      tx_lfsr_q   <= tx_lfsr_d;
      ref_lfsr_q  <= ref_lfsr_d;
      cnt_q       <= cnt_d;
      acc_i_q     <= acc_i_d;
      imp_i_q     <= imp_i_d;
      tx_dac_q    <= tx_dac_d;
      rx_strobe_q <= rx_strobe_d;
    end
  end

`ifdef SOUNDER_Q_CHANNEL_EN
  logic [31:0] acc_q_q, acc_q_d, acc_q_nxt;
  logic [15:0] imp_q_q, imp_q_d;
  logic [15:0] x_q;
  logic [16:0] prod_q;

  always_comb begin
    x_q       = mode_q[3] ? 16'd0 : rx_adc_q_i;
    prod_q    = corr_prod(x_q, ref_pn);
    acc_q_nxt = acc_q_q + {{15{prod_q[16]}}, prod_q};
    acc_q_d   = acc_q_q;
    imp_q_d   = imp_q_q;
    if (rx_go) begin
      if (period_end) begin
        acc_q_d = 32'd0;
        imp_q_d = sat16(acc_q_nxt, degree_q);
      end else begin
        acc_q_d = acc_q_nxt;
      end
    end
    if (soft_rst) begin
      acc_q_d = 32'd0;
      imp_q_d = 16'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc_q_q <= '0;
      imp_q_q <= '0;
    end else begin
      acc_q_q <= acc_q_d;
      imp_q_q <= imp_q_d;
    end
  end

  assign rx_imp_q_o = imp_q_q;

  logic unused_ok;
  assign unused_ok = ^sdata_i[31:14];
`else
  assign rx_imp_q_o = 16'd0;

  logic unused_ok;
  assign unused_ok = ^{sdata_i[31:14], rx_adc_q_i};
`endif

  assign tx_strobe_o = phase_q & mode_q[1];
  assign tx_dac_i_o  = tx_dac_q;
  assign tx_dac_q_o  = 14'd0;
  assign rx_strobe_o = rx_strobe_q;
  assign rx_imp_i_o  = imp_i_q;

endmodule

// File: tb/tb_sounder.sv
// tb_sounder: directed self-checking bench for the sounder core.
// Table of correlator scenarios plus hand sequences for reset, TX code
// properties, invalid degrees, amplitude update, soft reset and RX freeze.

module tb_sounder;

  localparam logic [6:0] FR_MODE   = 7'd64;
  localparam logic [6:0] FR_DEGREE = 7'd65;
  localparam logic [6:0] FR_AMPL   = 7'd66;

`ifdef SOUNDER_Q_CHANNEL_EN
  localparam bit Q_EN = 1'b1;
`else
  localparam bit Q_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [6:0]  saddr_i;
  logic [31:0] sdata_i;
  logic        s_strobe_i;
  logic        tx_strobe_o;
  logic [13:0] tx_dac_i_o;
  logic [13:0] tx_dac_q_o;
  logic        rx_strobe_o;
  logic [15:0] rx_adc_i_i;
  logic [15:0] rx_adc_q_i;
  logic [15:0] rx_imp_i_o;
  logic [15:0] rx_imp_q_o;

  sounder dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .saddr_i     (saddr_i),
    .sdata_i     (sdata_i),
    .s_strobe_i  (s_strobe_i),
    .tx_strobe_o (tx_strobe_o),
    .tx_dac_i_o  (tx_dac_i_o),
    .tx_dac_q_o  (tx_dac_q_o),
    .rx_strobe_o (rx_strobe_o),
    .rx_adc_i_i  (rx_adc_i_i),
    .rx_adc_q_i  (rx_adc_q_i),
    .rx_imp_i_o  (rx_imp_i_o),
    .rx_imp_q_o  (rx_imp_q_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  mode;
    logic [5:0]  degree;
    logic [13:0] ampl;
    logic [15:0] adc_i;
    logic [15:0] adc_q;
    int          n_samples;
    logic [15:0] peak_i;   // expected at lag 0 (sample index multiple of N)
    logic [15:0] rest_i;   // expected at every other lag
    logic [15:0] exp_q;
  } vec_t;

  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    saddr_i    = a;
    sdata_i    = d;
    s_strobe_i = 1'b1;
    tick();
    s_strobe_i = 1'b0;
    sdata_i    = 32'd0;
  endtask

  // Advance at least one clock, then until rx_strobe_o or the budget runs out.
  task automatic wait_rx(input int budget, output int cycles, output bit ok);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!rx_strobe_o && cycles < budget);
    ok = rx_strobe_o;
  endtask

  task automatic setup(input logic [5:0] deg, input logic [13:0] ampl);
    wr(FR_MODE, 32'h1);
    wr(FR_DEGREE, {26'd0, deg});
    wr(FR_AMPL, {18'd0, ampl});
    tick();
  endtask

  task automatic run_vec(input int v);
    vec_t t;
    int n, cyc, gap;
    bit ok;
    logic [15:0] exp;
    t = vecs[v];
    n = (1 << t.degree) - 1;
    rx_adc_i_i = t.adc_i;
    rx_adc_q_i = t.adc_q;
    setup(t.degree, t.ampl);
    wr(FR_MODE, {28'd0, t.mode});
    for (int k = 0; k < t.n_samples; k++) begin
      wait_rx(2 * n + 8, gap, ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL v%0d_timeout: no rx strobe after %0d cycles, required within %0d", v, gap, 2 * n);
        return;
      end
      check($sformatf("v%0d_interval%0d", v, k), gap, 2 * n);
      exp = ((k % n) == 0) ? t.peak_i : t.rest_i;
      check($sformatf("v%0d_imp_i%0d", v, k), rx_imp_i_o, exp);
      check($sformatf("v%0d_imp_q%0d", v, k), rx_imp_q_o, t.exp_q);
    end
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_c, cnt_d, gap;
    bit ok;
    logic [13:0] chips[510];
    int nch;
    logic [5:0] bad_deg[3];

    vecs[0] = '{4'hE, 6'd8, 14'h1000, 16'h1234, 16'h0555, 6,  16'h3FC0, 16'hFFC0, 16'h0000};
    vecs[1] = '{4'hE, 6'd4, 14'h1000, 16'h0000, 16'h0000, 32, 16'h3C00, 16'hFC00, 16'h0000};
    vecs[2] = '{4'h4, 6'd8, 14'h0000, 16'h0100, 16'h0200, 4,  16'h0001, 16'h0001,
                Q_EN ? 16'h0002 : 16'h0000};
    vecs[3] = '{4'h4, 6'd2, 14'h0000, 16'h7FFF, 16'h8000, 6,  16'h1FFF, 16'h1FFF,
                Q_EN ? 16'hE000 : 16'h0000};
    vecs[4] = '{4'h4, 6'd2, 14'h0000, 16'h8000, 16'h7FFF, 6,  16'hE000, 16'hE000,
                Q_EN ? 16'h1FFF : 16'h0000};
    vecs[5] = '{4'hE, 6'd3, 14'h1FFF, 16'h0000, 16'h0000, 14, 16'h6FFC, 16'hF000, 16'h0000};
    vecs[6] = '{4'hE, 6'd5, 14'h0100, 16'h0000, 16'h0000, 4,  16'h03E0, 16'hFFE0, 16'h0000};

    rst_n_i    = 1'b0;
    saddr_i    = 7'd0;
    sdata_i    = 32'd0;
    s_strobe_i = 1'b0;
    rx_adc_i_i = 16'h0123;
    rx_adc_q_i = 16'h0456;

    // ---- hard reset ----
    tick();
    tick();
    check("rst_tx_strobe", tx_strobe_o, 0);
    check("rst_tx_dac_i", tx_dac_i_o, 0);
    check("rst_tx_dac_q", tx_dac_q_o, 0);
    check("rst_rx_strobe", rx_strobe_o, 0);
    check("rst_imp_i", rx_imp_i_o, 0);
    check("rst_imp_q", rx_imp_q_o, 0);
    rst_n_i = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt_a += int'(tx_strobe_o) + int'(rx_strobe_o);
      if (tx_dac_i_o != 0) cnt_b++;
    end
    check("idle_strobes", cnt_a, 0);
    check("idle_dac", cnt_b, 0);

    // ---- TX only, degree 8 ----
    setup(6'd8, 14'h1000);
    wr(FR_MODE, 32'h2);
    nch   = 0;
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int i = 1; i <= 1020; i++) begin
      tick();
      if (tx_strobe_o != i[0]) cnt_a++;
      if (rx_strobe_o || tx_dac_q_o != 0) cnt_c++;
      if (tx_strobe_o && nch < 510) begin
        chips[nch] = tx_dac_i_o;
        nch++;
      end
    end
    check("tx_strobe_pattern", cnt_a, 0);
    check("tx_chip_count", nch, 510);
    check("tx_first_chip", chips[0], 14'h1000);
    cnt_a = 0;
    cnt_d = 0;
    for (int k = 0; k < 510; k++) begin
      if (chips[k] != 14'h1000 && chips[k] != 14'h3000) cnt_a++;
      if (k < 255 && chips[k] == 14'h1000) cnt_d++;
      if (k < 255 && chips[k] != chips[k + 255]) cnt_b++;
    end
    check("tx_values_legal", cnt_a, 0);
    check("tx_ones_per_period", cnt_d, 128);
    check("tx_period_255", cnt_b, 0);
    check("tx_only_quiet_rx_q", cnt_c, 0);

    // amplitude write takes effect on the next clock
    wr(FR_AMPL, 32'h0800);
    tick();
    check("ampl_update", (tx_dac_i_o == 14'h0800) || (tx_dac_i_o == 14'h3800), 1);

    // ---- invalid degrees: strobes continue, DAC stays at 0 ----
    bad_deg[0] = 6'd0;
    bad_deg[1] = 6'd1;
    bad_deg[2] = 6'd17;
    for (int d = 0; d < 3; d++) begin
      setup(bad_deg[d], 14'h1000);
      wr(FR_MODE, 32'h6);
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (tx_dac_i_o != 0 || rx_strobe_o) cnt_a++;
        if (tx_strobe_o) cnt_b++;
      end
      check($sformatf("bad_deg%0d_dac", bad_deg[d]), cnt_a, 0);
      check($sformatf("bad_deg%0d_strobes", bad_deg[d]), cnt_b, 20);
    end

    // ---- correlator table ----
    for (int v = 0; v < 7; v++) run_vec(v);

    // ---- soft reset mid-period, loopback degree 4 ----
    rx_adc_i_i = 16'h0000;
    rx_adc_q_i = 16'h0000;
    setup(6'd4, 14'h1000);
    wr(FR_MODE, 32'hE);
    for (int k = 0; k < 3; k++) wait_rx(40, gap, ok);
    check("sr_pre_imp", rx_imp_i_o, 16'hFC00);
    repeat (7) tick();
    wr(FR_MODE, 32'hF);
    tick();
    check("sr_tx_dac", tx_dac_i_o, 0);
    check("sr_imp_i", rx_imp_i_o, 0);
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_strobe_o || rx_strobe_o || tx_dac_i_o != 0 || rx_imp_i_o != 0) cnt_a++;
    end
    check("sr_hold_quiet", cnt_a, 0);
    wr(FR_MODE, 32'hE);
    wait_rx(40, gap, ok);
    check("sr_release_latency", gap, 30);
    check("sr_release_peak", rx_imp_i_o, 16'h3C00);

    // ---- RX disabled: receiver frozen ----
    wr(FR_MODE, 32'hA);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rx_strobe_o) cnt_a++;
      if (rx_imp_i_o != 16'h3C00) cnt_b++;
    end
    check("rx_off_strobes", cnt_a, 0);
    check("rx_off_hold", cnt_b, 0);

    // ---- hard reset while running clears registers too ----
    rst_n_i = 1'b0;
    tick();
    tick();
    check("rst2_imp_i", rx_imp_i_o, 0);
    check("rst2_tx_dac", tx_dac_i_o, 0);
    rst_n_i = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_strobe_o || rx_strobe_o || tx_dac_i_o != 0) cnt_a++;
    end
    check("rst2_mode_cleared", cnt_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
